// File: rtl/m_load_unit_pkg.sv
// Shared memory-stage definitions: load type codes, address map and load FSM states.
package m_load_unit_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned TYPE_W = 3;

  localparam logic [TYPE_W-1:0] LD_NONE = 3'd0;
  localparam logic [TYPE_W-1:0] LD_LW   = 3'd1;
  localparam logic [TYPE_W-1:0] LD_LH   = 3'd2;
  localparam logic [TYPE_W-1:0] LD_LHU  = 3'd3;
  localparam logic [TYPE_W-1:0] LD_LB   = 3'd4;
  localparam logic [TYPE_W-1:0] LD_LBU  = 3'd5;

  localparam logic [ADDR_W-1:0] DM_END   = 32'h0000_2FFF;
  localparam logic [ADDR_W-1:0] TC0_BASE = 32'h0000_7F00;
  localparam logic [ADDR_W-1:0] TC1_BASE = 32'h0000_7F10;
  localparam logic [ADDR_W-1:0] IG_BASE  = 32'h0000_7F20;
  localparam logic [ADDR_W-1:0] TC_SPAN  = 32'd11;
  localparam logic [ADDR_W-1:0] IG_SPAN  = 32'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DONE  = 2'd2,
    ST_DRAIN = 2'd3
  } ld_state_e;

  function automatic logic ld_legal(input logic [TYPE_W-1:0] t);
    return (t >= LD_LW) && (t <= LD_LBU);
  endfunction

  function automatic logic in_range(input logic [ADDR_W-1:0] a,
                                    input logic [ADDR_W-1:0] base,
                                    input logic [ADDR_W-1:0] span);
    return (a >= base) && (a <= base + span);
  endfunction

endpackage

// File: rtl/m_load_ext.sv
// Byte/halfword select and sign/zero extension of a read word.
module m_load_ext
  import m_load_unit_pkg::*;
(
  input  logic [DATA_W-1:0] rdata,
  input  logic [TYPE_W-1:0] ld_type,
  input  logic [1:0]        offset,
  output logic [DATA_W-1:0] data
);

  logic [15:0] half;
  logic [7:0]  bsel;

  always_comb begin
    half = offset[1] ? rdata[31:16] : rdata[15:0];
    case (offset)
      2'd0:    bsel = rdata[7:0];
      2'd1:    bsel = rdata[15:8];
      2'd2:    bsel = rdata[23:16];
      default: bsel = rdata[31:24];
    endcase
    case (ld_type)
      LD_LH:   data = {{16{half[15]}}, half};
      LD_LHU:  data = {16'h0000, half};
      LD_LB:   data = {{24{bsel[7]}}, bsel};
      LD_LBU:  data = {24'h00_0000, bsel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/m_load_unit.sv
// Memory-stage load engine: AdEL detection, word read over the bridge, extension and stall.
module m_load_unit
  import m_load_unit_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_valid,
  input  logic [2:0]        ld_type,
  input  logic [31:0]       ld_addr,
  input  logic              req,
  output logic              bus_req,
  output logic [31:0]       bus_addr,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata,
  output logic              ld_stall,
  output logic              ld_done,
  output logic [31:0]       ld_data,
  output logic              exc_adel
);

  ld_state_e         state;
  logic [TYPE_W-1:0] lat_type;
  logic [1:0]        lat_off;
  logic [DATA_W-1:0] ext_data;
  logic              legal, is_tc, in_map, misal, adel_raw, go, start;

  // Address error and stall decode; forced low while reset is held.
  always_comb begin
    legal    = ld_legal(ld_type);
    is_tc    = in_range(ld_addr, TC0_BASE, TC_SPAN) | in_range(ld_addr, TC1_BASE, TC_SPAN);
    in_map   = (ld_addr <= DM_END) | is_tc | in_range(ld_addr, IG_BASE, IG_SPAN);
    misal    = ((ld_type == LD_LW) && (ld_addr[1:0] != 2'b00)) |
               (((ld_type == LD_LH) || (ld_type == LD_LHU)) && ld_addr[0]);
    adel_raw = ld_valid & legal & (misal | !in_map | ((ld_type != LD_LW) & is_tc));
    go       = ld_valid & legal & !adel_raw & !req;
    start    = go & (state == ST_IDLE);
    exc_adel = adel_raw & !reset;
    ld_stall = go & (state != ST_DONE) & !reset;
  end

  m_load_ext u_ext (
    .rdata   (bus_rdata),
    .ld_type (lat_type),
    .offset  (lat_off),
    .data    (ext_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      bus_req  <= 1'b0;
      bus_addr <= '0;
      ld_done  <= 1'b0;
      ld_data  <= '0;
      lat_type <= LD_NONE;
      lat_off  <= 2'b00;
    end else begin
      ld_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            bus_addr <= {ld_addr[31:2], 2'b00};
            lat_type <= ld_type;
            lat_off  <= ld_addr[1:0];
            bus_req  <= 1'b1;
            state    <= ST_REQ;
          end
        end
        ST_REQ: begin
          // A flush in the ack cycle wins: data is dropped and no done pulse.
          if (bus_ack && req) begin
            bus_req <= 1'b0;
            state   <= ST_IDLE;
          end else if (bus_ack) begin
            bus_req <= 1'b0;
            ld_data <= ext_data;
            ld_done <= 1'b1;
            state   <= ST_DONE;
          end else if (req) begin
            state <= ST_DRAIN;
          end
        end
        ST_DONE: state <= ST_IDLE;
        ST_DRAIN: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
